// File: rtl/br_pkg.sv
// Package: br_pkg
// Shared definitions for the decode-stage branch predictor and the EX-stage
// branch resolve unit.
//  - Branch class codes: 0-7 are real branches (BEQ..BGEZAL); 8-15 mean
//    "not a branch" (BR_NONE is the canonical value).
//  - Resolve-unit FSM state encoding.
//  - is_branch(): classifies a 4-bit decode class code.
package br_pkg;

  localparam logic [3:0] BR_BEQ    = 4'd0;
  localparam logic [3:0] BR_BNE    = 4'd1;
  localparam logic [3:0] BR_BLEZ   = 4'd2;
  localparam logic [3:0] BR_BGTZ   = 4'd3;
  localparam logic [3:0] BR_BLTZ   = 4'd4;
  localparam logic [3:0] BR_BGEZ   = 4'd5;
  localparam logic [3:0] BR_BLTZAL = 4'd6;
  localparam logic [3:0] BR_BGEZAL = 4'd7;
  localparam logic [3:0] BR_NONE   = 4'd8;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    SQUASH = 1'b1
  } brs_state_e;

  // Classes with the top bit set are not branches.
  function automatic logic is_branch(input logic [3:0] br);
    return ~br[3];
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Module: sat_counter
// Up-counter that sticks at all-ones instead of wrapping.
// Ports:
//  clk    in  1  rising-edge clock
//  rst_n  in  1  synchronous reset, active low (clears count)
//  inc    in  1  add one at the next edge (ignored once saturated)
//  count  out W  current count
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  // Next count: increment unless already saturated.
  always_comb begin
    count_d = count_q;
    if (inc && (count_q != {W{1'b1}})) begin
      count_d = count_q + {{(W-1){1'b0}}, 1'b1};
    end else begin
      count_d = count_q;
    end
  end

  // Count register with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q <= {W{1'b0}};
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/branch_resolve_unit.sv
// Module: branch_resolve_unit
// EX-stage branch resolution. Captures the decode-stage prediction as the
// branch moves D->E, compares it with the real EX outcome, redirects fetch and
// squashes IF/ID and ID/EX on a mispredict, and returns a registered training
// update to the predictor. Keeps saturating branch/mispredict statistics.
// Ports:
//  clk, rst_n                      clock, synchronous active-low reset
//  d_valid, d_br, d_pred_taken,
//  d_pred_pc, d_pc_plus4           decode-stage instruction and its prediction
//  d_stall                         hold the E register (load-use stall)
//  e_actual_taken, e_target        resolved outcome/target from EX
//  redirect_valid, redirect_pc     fetch correction (same cycle as detection)
//  flush_ifid, flush_idex          squash wrong-path stages at next edge
//  train_valid, train_br,
//  train_taken                     one-cycle predictor update, cycle after resolve
//  branch_cnt, mispred_cnt         saturating statistics
module branch_resolve_unit
  import br_pkg::*;
#(
  parameter int AW    = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             d_valid,
  input  logic [3:0]       d_br,
  input  logic             d_pred_taken,
  input  logic [AW-1:0]    d_pred_pc,
  input  logic [AW-1:0]    d_pc_plus4,
  input  logic             d_stall,
  input  logic             e_actual_taken,
  input  logic [AW-1:0]    e_target,
  output logic             redirect_valid,
  output logic [AW-1:0]    redirect_pc,
  output logic             flush_ifid,
  output logic             flush_idex,
  output logic             train_valid,
  output logic [2:0]       train_br,
  output logic             train_taken,
  output logic [CNT_W-1:0] branch_cnt,
  output logic [CNT_W-1:0] mispred_cnt
);

  // E-stage branch slot
  logic          e_valid_q,      e_valid_d;
  logic [2:0]    e_br_q,         e_br_d;
  logic          e_pred_taken_q, e_pred_taken_d;
  logic [AW-1:0] e_pred_pc_q,    e_pred_pc_d;
  logic [AW-1:0] e_pc_plus4_q,   e_pc_plus4_d;
  // Set once the held branch has resolved, so a stall does not re-resolve it.
  logic          fired_q,        fired_d;

  brs_state_e    state_q,        state_d;

  logic          train_valid_q,  train_valid_d;
  logic [2:0]    train_br_q,     train_br_d;
  logic          train_taken_q,  train_taken_d;

  logic          resolve_s;
  logic          mispredict_s;

  // Resolution and mispredict detection for the branch currently in E.
  always_comb begin
    resolve_s    = e_valid_q & (state_q == IDLE) & ~fired_q;
    mispredict_s = resolve_s &
                   ((e_pred_taken_q != e_actual_taken) |
                    (e_pred_taken_q & e_actual_taken & (e_pred_pc_q != e_target)));
  end

  // Fetch redirect and squash; redirect_pc is forced to zero when idle.
  always_comb begin
    redirect_valid = mispredict_s;
    flush_ifid     = mispredict_s;
    flush_idex     = mispredict_s;
    if (mispredict_s) begin
      redirect_pc = e_actual_taken ? e_target : e_pc_plus4_q;
    end else begin
      redirect_pc = {AW{1'b0}};
    end
  end

  // E register next value: flush beats stall, stall beats load.
  always_comb begin
    e_valid_d      = e_valid_q;
    e_br_d         = e_br_q;
    e_pred_taken_d = e_pred_taken_q;
    e_pred_pc_d    = e_pred_pc_q;
    e_pc_plus4_d   = e_pc_plus4_q;
    fired_d        = fired_q;
    if (mispredict_s) begin
      e_valid_d = 1'b0;
      fired_d   = 1'b0;
    end else if (d_stall) begin
      fired_d = fired_q | resolve_s;
    end else begin
      e_valid_d      = d_valid & is_branch(d_br);
      e_br_d         = d_br[2:0];
      e_pred_taken_d = d_pred_taken;
      e_pred_pc_d    = d_pred_pc;
      e_pc_plus4_d   = d_pc_plus4;
      fired_d        = 1'b0;
    end
  end

  // FSM next state: a mispredict costs exactly one squash cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = mispredict_s ? SQUASH : IDLE;
      SQUASH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Training payload, registered for presentation one cycle after resolve.
  always_comb begin
    train_valid_d = resolve_s;
    if (resolve_s) begin
      train_br_d    = e_br_q;
      train_taken_d = e_actual_taken;
    end else begin
      train_br_d    = 3'd0;
      train_taken_d = 1'b0;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      e_valid_q      <= 1'b0;
      e_br_q         <= 3'd0;
      e_pred_taken_q <= 1'b0;
      e_pred_pc_q    <= {AW{1'b0}};
      e_pc_plus4_q   <= {AW{1'b0}};
      fired_q        <= 1'b0;
      state_q        <= IDLE;
      train_valid_q  <= 1'b0;
      train_br_q     <= 3'd0;
      train_taken_q  <= 1'b0;
    end else begin
      e_valid_q      <= e_valid_d;
      e_br_q         <= e_br_d;
      e_pred_taken_q <= e_pred_taken_d;
      e_pred_pc_q    <= e_pred_pc_d;
      e_pc_plus4_q   <= e_pc_plus4_d;
      fired_q        <= fired_d;
      state_q        <= state_d;
      train_valid_q  <= train_valid_d;
      train_br_q     <= train_br_d;
      train_taken_q  <= train_taken_d;
    end
  end

  assign train_valid = train_valid_q;
  assign train_br    = train_br_q;
  assign train_taken = train_taken_q;

  sat_counter #(.W(CNT_W)) u_branch_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (resolve_s),
    .count (branch_cnt)
  );

  sat_counter #(.W(CNT_W)) u_mispred_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (mispredict_s),
    .count (mispred_cnt)
  );

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Testbench for branch_resolve_unit (AW=32, CNT_W=4). Directed branch vectors
// push their expected redirect and training responses into queues; a monitor
// on the falling edge pops and compares whenever the DUT presents an output.
module tb_branch_resolve_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        d_valid;
  logic [3:0]  d_br;
  logic        d_pred_taken;
  logic [31:0] d_pred_pc;
  logic [31:0] d_pc_plus4;
  logic        d_stall;
  logic        e_actual_taken;
  logic [31:0] e_target;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        flush_ifid;
  logic        flush_idex;
  logic        train_valid;
  logic [2:0]  train_br;
  logic        train_taken;
  logic [3:0]  branch_cnt;
  logic [3:0]  mispred_cnt;

  always #5 clk = ~clk;

  branch_resolve_unit #(.AW(32), .CNT_W(4)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .d_valid        (d_valid),
    .d_br           (d_br),
    .d_pred_taken   (d_pred_taken),
    .d_pred_pc      (d_pred_pc),
    .d_pc_plus4     (d_pc_plus4),
    .d_stall        (d_stall),
    .e_actual_taken (e_actual_taken),
    .e_target       (e_target),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .flush_ifid     (flush_ifid),
    .flush_idex     (flush_idex),
    .train_valid    (train_valid),
    .train_br       (train_br),
    .train_taken    (train_taken),
    .branch_cnt     (branch_cnt),
    .mispred_cnt    (mispred_cnt)
  );

  typedef struct packed {
    logic [2:0] br;
    logic       taken;
    logic [3:0] bcnt;
    logic [3:0] mcnt;
  } train_t;

  logic [31:0] redir_q[$];
  train_t      train_q[$];

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: compare every presented redirect/training against the queues.
  always @(negedge clk) begin
    if (redirect_valid === 1'b1) begin
      if (redir_q.size() == 0) begin
        chk("unexpected_redirect", 64'(redirect_valid), 64'd0);
      end else begin
        logic [31:0] pc_exp;
        pc_exp = redir_q.pop_front();
        chk("redirect_pc", 64'(redirect_pc), 64'(pc_exp));
        chk("flush_ifid", 64'(flush_ifid), 64'd1);
        chk("flush_idex", 64'(flush_idex), 64'd1);
      end
    end else if ((flush_ifid === 1'b1) || (flush_idex === 1'b1)) begin
      chk("flush_without_redirect", 64'({flush_ifid, flush_idex}), 64'd0);
    end
    if (train_valid === 1'b1) begin
      if (train_q.size() == 0) begin
        chk("unexpected_train", 64'(train_valid), 64'd0);
      end else begin
        train_t t;
        t = train_q.pop_front();
        chk("train_br", 64'(train_br), 64'(t.br));
        chk("train_taken", 64'(train_taken), 64'(t.taken));
        chk("branch_cnt", 64'(branch_cnt), 64'(t.bcnt));
        chk("mispred_cnt", 64'(mispred_cnt), 64'(t.mcnt));
      end
    end
  end

  task automatic check_all_zero(input string tag);
    chk({tag, "_redirect_valid"}, 64'(redirect_valid), 64'd0);
    chk({tag, "_redirect_pc"}, 64'(redirect_pc), 64'd0);
    chk({tag, "_flushes"}, 64'({flush_ifid, flush_idex}), 64'd0);
    chk({tag, "_train"}, 64'({train_valid, train_br, train_taken}), 64'd0);
    chk({tag, "_counters"}, 64'({branch_cnt, mispred_cnt}), 64'd0);
  endtask

  // Put one instruction into decode, then resolve it in E. When is_br is set
  // the expected responses are queued; the instruction may be held in E by a
  // stall of stall_cycles cycles.
  task automatic issue(input logic [3:0] br, input logic pt, input logic [31:0] ppc,
                       input logic [31:0] pc4, input logic act, input logic [31:0] tgt,
                       input logic is_br, input logic exp_mis, input logic [3:0] bc,
                       input logic [3:0] mc, input int stall_cycles, input int tail);
    train_t t;
    @(posedge clk); #1;
    d_valid = 1'b1; d_br = br; d_pred_taken = pt; d_pred_pc = ppc; d_pc_plus4 = pc4;
    @(posedge clk); #1;
    d_valid = 1'b0; d_br = 4'd8;
    e_actual_taken = act; e_target = tgt;
    d_stall = (stall_cycles > 0);
    if (is_br) begin
      if (exp_mis) redir_q.push_back(act ? tgt : pc4);
      t.br = br[2:0]; t.taken = act; t.bcnt = bc; t.mcnt = mc;
      train_q.push_back(t);
    end
    for (int k = 0; k < stall_cycles; k++) begin
      @(posedge clk); #1;
    end
    d_stall = 1'b0;
    repeat (tail) @(posedge clk);
  endtask

  initial begin
    rst_n = 1'b0; d_valid = 1'b0; d_br = 4'd8; d_pred_taken = 1'b0;
    d_pred_pc = 32'd0; d_pc_plus4 = 32'd0; d_stall = 1'b0;
    e_actual_taken = 1'b0; e_target = 32'd0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    check_all_zero("reset");

    // 1: BEQ correctly predicted not-taken
    issue(4'd0, 1'b0, 32'h0, 32'h104, 1'b0, 32'h200, 1'b1, 1'b0, 4'd1, 4'd0, 0, 3);
    // 2: BNE taken, predicted not-taken -> redirect to target
    issue(4'd1, 1'b0, 32'h0, 32'h104, 1'b1, 32'h200, 1'b1, 1'b1, 4'd2, 4'd1, 0, 3);
    // 3: BGTZ predicted taken, not taken -> redirect to pc+4
    issue(4'd3, 1'b1, 32'h300, 32'h108, 1'b0, 32'h300, 1'b1, 1'b1, 4'd3, 4'd2, 0, 3);
    // taken/taken but wrong predicted target
    issue(4'd0, 1'b1, 32'h400, 32'h10c, 1'b1, 32'h500, 1'b1, 1'b1, 4'd4, 4'd3, 0, 3);
    // 4: correct taken BLEZ held in E by a 3-cycle stall -> one resolution
    issue(4'd2, 1'b1, 32'h600, 32'h110, 1'b1, 32'h600, 1'b1, 1'b0, 4'd5, 4'd3, 3, 3);
    // non-branch in decode never resolves, even with a would-be mispredict
    issue(4'd9, 1'b0, 32'h0, 32'h114, 1'b1, 32'h900, 1'b0, 1'b0, 4'd0, 4'd0, 0, 3);
    #1;
    chk("cnt_after_nonbranch", 64'({branch_cnt, mispred_cnt}), 64'({4'd5, 4'd3}));

    // 6: reset asserted during the SQUASH cycle
    @(posedge clk); #1;
    d_valid = 1'b1; d_br = 4'd0; d_pred_taken = 1'b0; d_pc_plus4 = 32'h704;
    @(posedge clk); #1;
    d_valid = 1'b0; d_br = 4'd8; e_actual_taken = 1'b1; e_target = 32'h700;
    begin
      train_t t;
      redir_q.push_back(32'h700);
      t.br = 3'd0; t.taken = 1'b1; t.bcnt = 4'd6; t.mcnt = 4'd4;
      train_q.push_back(t);
    end
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    check_all_zero("after_mid_reset");
    issue(4'd5, 1'b0, 32'h0, 32'h804, 1'b0, 32'h880, 1'b1, 1'b0, 4'd1, 4'd0, 0, 3);

    // 5: 20 mispredicts; both counters saturate at 0xF
    for (int k = 1; k <= 20; k++) begin
      int b;
      int m;
      b = (k + 1 > 15) ? 15 : k + 1;
      m = (k > 15) ? 15 : k;
      issue(4'd1, 1'b0, 32'h0, 32'h1000 + 32'(k * 8), 1'b1, 32'h2000 + 32'(k * 16),
            1'b1, 1'b1, 4'(b), 4'(m), 0, 2);
    end
    repeat (2) @(posedge clk);
    #1;
    chk("branch_cnt_sat", 64'(branch_cnt), 64'hF);
    chk("mispred_cnt_sat", 64'(mispred_cnt), 64'hF);
    chk("redirects_outstanding", 64'(redir_q.size()), 64'd0);
    chk("trains_outstanding", 64'(train_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
